// File: rtl/bram_arb_pkg.sv
// Shared encodings for the two-master BRAM Wishbone arbiter.
// FSM state codes are plain constants so legacy code can compare against them directly.
package bram_arb_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_GNT0 = 2'd1;
    localparam logic [1:0] ST_GNT1 = 2'd2;

    localparam int TIMEOUT_DEF = 16;

endpackage

// File: rtl/bram_arb_rr.sv
// Two-way round-robin pick: purely combinational, zero latency, no backpressure of its own.
// On a tie the master that did not win last time is chosen.
module bram_arb_rr
    import bram_arb_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last_gnt,
    output logic gnt_idx,
    output logic gnt_vld
);

    always_comb begin
        gnt_vld = req0 | req1;
        gnt_idx = (req0 & req1) ? ~last_gnt : req1;
    end

endmodule

// File: rtl/bram_arb_wb.sv
// Wishbone arbiter sharing one BRAM slave between CPU (M0) and DMA (M1), one access per grant.
// Grant one edge after request; slave stalls are bounded by TIMEOUT, after which the master gets err.
module bram_arb_wb
    import bram_arb_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF,
    parameter int ADR_W   = 30
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,

    input  logic [ADR_W-1:0] m0_adr_i,
    input  logic [31:0]      m0_dat_i,
    output logic [31:0]      m0_dat_o,
    input  logic             m0_we_i,
    input  logic [3:0]       m0_sel_i,
    input  logic             m0_stb_i,
    input  logic             m0_cyc_i,
    output logic             m0_ack_o,
    output logic             m0_err_o,

    input  logic [ADR_W-1:0] m1_adr_i,
    input  logic [31:0]      m1_dat_i,
    output logic [31:0]      m1_dat_o,
    input  logic             m1_we_i,
    input  logic [3:0]       m1_sel_i,
    input  logic             m1_stb_i,
    input  logic             m1_cyc_i,
    output logic             m1_ack_o,
    output logic             m1_err_o,

    output logic [ADR_W-1:0] s_adr_o,
    output logic [31:0]      s_dat_o,
    input  logic [31:0]      s_dat_i,
    output logic             s_we_o,
    output logic [3:0]       s_sel_o,
    output logic             s_stb_o,
    output logic             s_cyc_o,
    input  logic             s_ack_i
);

    localparam int             CW       = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT - 1);

    logic [1:0]    state_q, state_d;
    logic          last_gnt_q, last_gnt_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic gnt_idx, gnt_vld;
    logic gnt0, gnt1, busy, tmo_fire;
    logic cur_idx, cur_cyc;

    bram_arb_rr u_rr (
        .req0     (m0_cyc_i & m0_stb_i),
        .req1     (m1_cyc_i & m1_stb_i),
        .last_gnt (last_gnt_q),
        .gnt_idx  (gnt_idx),
        .gnt_vld  (gnt_vld)
    );

    // Reset gates the outputs so a grant in flight is dropped silently that same cycle.
    always_comb begin
        gnt0     = wb_rst_i && (state_q == ST_GNT0);
        gnt1     = wb_rst_i && (state_q == ST_GNT1);
        busy     = gnt0 | gnt1;
        tmo_fire = busy && (cnt_q == CNT_LAST) && !s_ack_i;

        s_adr_o  = gnt1 ? m1_adr_i : (gnt0 ? m0_adr_i : '0);
        s_dat_o  = gnt1 ? m1_dat_i : (gnt0 ? m0_dat_i : '0);
        s_we_o   = gnt1 ? m1_we_i  : (gnt0 ? m0_we_i  : 1'b0);
        s_sel_o  = gnt1 ? m1_sel_i : (gnt0 ? m0_sel_i : 4'h0);
        s_stb_o  = !tmo_fire && (gnt1 ? m1_stb_i : (gnt0 && m0_stb_i));
        s_cyc_o  = !tmo_fire && (gnt1 ? m1_cyc_i : (gnt0 && m0_cyc_i));

        m0_ack_o = gnt0 && s_ack_i;
        m1_ack_o = gnt1 && s_ack_i;
        m0_err_o = gnt0 && tmo_fire;
        m1_err_o = gnt1 && tmo_fire;
        m0_dat_o = gnt0 ? s_dat_i : 32'h0;
        m1_dat_o = gnt1 ? s_dat_i : 32'h0;
    end

    always_comb begin
        state_d    = state_q;
        last_gnt_d = last_gnt_q;
        cnt_d      = cnt_q;
        cur_idx    = (state_q == ST_GNT1);
        cur_cyc    = cur_idx ? m1_cyc_i : m0_cyc_i;

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (gnt_vld) begin
                    state_d = gnt_idx ? ST_GNT1 : ST_GNT0;
                end
            end
            ST_GNT0, ST_GNT1: begin
                if (s_ack_i) begin
                    state_d    = ST_IDLE;
                    last_gnt_d = cur_idx;
                    cnt_d      = '0;
                end else if (!cur_cyc) begin
                    // Master gave up: no response, and it keeps its round-robin standing.
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d    = ST_IDLE;
                    last_gnt_d = cur_idx;
                    cnt_d      = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_i) begin
            state_q    <= ST_IDLE;
            last_gnt_q <= 1'b1;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
            cnt_q      <= cnt_d;
        end
    end

endmodule
